// File: rtl/basic_gates_pkg.sv
// Shared types and constants for the basic-gates checker: FSM states,
// expected gate-output vectors and the bit layout of the observed vector.
package basic_gates_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    // Expected {AND, OR, NAND, NOR, XOR, XNOR, A_INV, B_BUFF} for each {A,B}.
    localparam logic [7:0] EXP_00 = 8'h36;
    localparam logic [7:0] EXP_01 = 8'h6B;
    localparam logic [7:0] EXP_10 = 8'h68;
    localparam logic [7:0] EXP_11 = 8'hC5;

    localparam int BIT_AND  = 7;
    localparam int BIT_OR   = 6;
    localparam int BIT_NAND = 5;
    localparam int BIT_NOR  = 4;
    localparam int BIT_XOR  = 3;
    localparam int BIT_XNOR = 2;
    localparam int BIT_INV  = 1;
    localparam int BIT_BUFF = 0;

endpackage

// File: rtl/basic_gates_expect.sv
// Combinational lookup from input vector {A,B} to the expected eight gate
// outputs, ordered as the observed vector.
module basic_gates_expect
    import basic_gates_pkg::*;
(
    input  logic [1:0] vec,
    output logic [7:0] expected
);

    always_comb begin
        case (vec)
            2'b00:   expected = EXP_00;
            2'b01:   expected = EXP_01;
            2'b10:   expected = EXP_10;
            default: expected = EXP_11;
        endcase
    end

endmodule

// File: rtl/basic_gates_checker.sv
// Self-test exerciser for the two-input gates block: sweeps {A,B} through
// 00..11, holds each for SETTLE_CYCLES, compares the eight returned outputs.
module basic_gates_checker
    import basic_gates_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    output logic       A_OUT,
    output logic       B_OUT,
    input  logic       AB_AND,
    input  logic       AB_OR,
    input  logic       AB_NAND,
    input  logic       AB_NOR,
    input  logic       AB_XOR,
    input  logic       AB_XNOR,
    input  logic       A_INV,
    input  logic       B_BUFF,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] ERR_COUNT,
    output logic [1:0] FIRST_FAIL_VEC,
    output logic [7:0] FIRST_FAIL_MASK
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [2:0]       err_q, err_d;
    logic [1:0]       ffv_q, ffv_d;
    logic [7:0]       ffm_q, ffm_d;

    logic [7:0] expected;
    logic [7:0] observed;
    logic [7:0] diff;
    logic       mismatch;
    logic [2:0] err_next;

    basic_gates_expect u_expect (
        .vec      (vec_q),
        .expected (expected)
    );

    always_comb begin
        observed           = '0;
        observed[BIT_AND]  = AB_AND;
        observed[BIT_OR]   = AB_OR;
        observed[BIT_NAND] = AB_NAND;
        observed[BIT_NOR]  = AB_NOR;
        observed[BIT_XOR]  = AB_XOR;
        observed[BIT_XNOR] = AB_XNOR;
        observed[BIT_INV]  = A_INV;
        observed[BIT_BUFF] = B_BUFF;
    end

    assign diff     = expected ^ observed;
    assign mismatch = |diff;
    // PASS on the last vector must see this vector's result, hence the
    // combinational next count rather than err_q.
    assign err_next = err_q + {2'b00, mismatch};

    always_comb begin
        // NOTE: every variable gets a hold default first so no path through
        // the case statement infers a latch.
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffm_d   = ffm_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = ST_SETTLE;
                    vec_d   = 2'b00;
                    cnt_d   = RELOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ffv_d   = '0;
                    ffm_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_CHECK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_next;
                    if (err_q == '0) begin
                        ffv_d = vec_q;
                        ffm_d = diff;
                    end
                end
                if (vec_q != 2'b11) begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = RELOAD;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            ffv_q  <= '0;
            ffm_q  <= '0;
        end else begin
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            err_q  <= err_d;
            ffv_q  <= ffv_d;
            ffm_q  <= ffm_d;
        end
    end

    assign A_OUT           = vec_q[1];
    assign B_OUT           = vec_q[0];
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign PASS            = pass_q;
    assign ERR_COUNT       = err_q;
    assign FIRST_FAIL_VEC  = ffv_q;
    assign FIRST_FAIL_MASK = ffm_q;

endmodule

// File: tb/tb_basic_gates_checker.sv
// Directed bench for basic_gates_checker: three instances (SETTLE 2, 1, 15)
// driving a behavioural gates block, with stuck-at faults on the first.
module tb_basic_gates_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Fault controls for the SETTLE_CYCLES=2 instance's gates block.
    logic xor_stuck0, and_stuck0, all_zero;

    // ---------------- instance with SETTLE_CYCLES = 2 ----------------
    logic       start2, a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [1:0] ffv2;
    logic [7:0] ffm2;
    logic g2_and, g2_or, g2_nand, g2_nor, g2_xor, g2_xnor, g2_inv, g2_buff;

    assign g2_and  = (all_zero || and_stuck0) ? 1'b0 : (a2 & b2);
    assign g2_or   = all_zero ? 1'b0 : (a2 | b2);
    assign g2_nand = all_zero ? 1'b0 : ~(a2 & b2);
    assign g2_nor  = all_zero ? 1'b0 : ~(a2 | b2);
    assign g2_xor  = (all_zero || xor_stuck0) ? 1'b0 : (a2 ^ b2);
    assign g2_xnor = all_zero ? 1'b0 : ~(a2 ^ b2);
    assign g2_inv  = all_zero ? 1'b0 : ~a2;
    assign g2_buff = all_zero ? 1'b0 : b2;

    basic_gates_checker #(.SETTLE_CYCLES(2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .A_OUT(a2), .B_OUT(b2),
        .AB_AND(g2_and), .AB_OR(g2_or), .AB_NAND(g2_nand), .AB_NOR(g2_nor),
        .AB_XOR(g2_xor), .AB_XNOR(g2_xnor), .A_INV(g2_inv), .B_BUFF(g2_buff),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_COUNT(err2),
        .FIRST_FAIL_VEC(ffv2), .FIRST_FAIL_MASK(ffm2)
    );

    // ---------------- instance with SETTLE_CYCLES = 1 ----------------
    logic       start1, a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] ffv1;
    logic [7:0] ffm1;

    basic_gates_checker #(.SETTLE_CYCLES(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .A_OUT(a1), .B_OUT(b1),
        .AB_AND(a1 & b1), .AB_OR(a1 | b1), .AB_NAND(~(a1 & b1)), .AB_NOR(~(a1 | b1)),
        .AB_XOR(a1 ^ b1), .AB_XNOR(~(a1 ^ b1)), .A_INV(~a1), .B_BUFF(b1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_COUNT(err1),
        .FIRST_FAIL_VEC(ffv1), .FIRST_FAIL_MASK(ffm1)
    );

    // ---------------- instance with SETTLE_CYCLES = 15 ---------------
    logic       start15, a15, b15, busy15, done15, pass15;
    logic [2:0] err15;
    logic [1:0] ffv15;
    logic [7:0] ffm15;

    basic_gates_checker #(.SETTLE_CYCLES(15)) dut15 (
        .CLK(clk), .RST_N(rst_n), .START(start15), .A_OUT(a15), .B_OUT(b15),
        .AB_AND(a15 & b15), .AB_OR(a15 | b15), .AB_NAND(~(a15 & b15)), .AB_NOR(~(a15 | b15)),
        .AB_XOR(a15 ^ b15), .AB_XNOR(~(a15 ^ b15)), .A_INV(~a15), .B_BUFF(b15),
        .BUSY(busy15), .DONE(done15), .PASS(pass15), .ERR_COUNT(err15),
        .FIRST_FAIL_VEC(ffv15), .FIRST_FAIL_MASK(ffm15)
    );

    // ---------------- per-instance accessors ----------------
    function automatic logic [1:0] get_vec(input int sel);
        case (sel)
            1:       return {a1, b1};
            15:      return {a15, b15};
            default: return {a2, b2};
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            1:       return done1;
            15:      return done15;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1:       return busy1;
            15:      return busy15;
            default: return busy2;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic val);
        case (sel)
            1:       start1  = val;
            15:      start15 = val;
            default: start2  = val;
        endcase
    endtask

    // Snapshot of dut2 results right after the START edge.
    logic       snap_done, snap_pass, snap_busy;
    logic [2:0] snap_err;
    logic [7:0] snap_ffm;

    // Pulses START, then follows the sweep edge by edge. The {A,B} and BUSY
    // trace is checked against the ideal schedule: vector k/(S+1), capped at 3.
    task automatic run_sweep(input int sel, input int settle, input int repulse_at,
                             output int latency, output int trace_errs);
        int exp_v;
        int limit;
        limit      = 4 * (settle + 1) + 20;
        latency    = -1;
        trace_errs = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        snap_done = done2; snap_pass = pass2; snap_busy = busy2;
        snap_err  = err2;  snap_ffm  = ffm2;
        if (get_vec(sel) != 2'b00 || get_busy(sel) != 1'b1) trace_errs++;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (k == repulse_at)     set_start(sel, 1'b1);
            if (k == repulse_at + 1) set_start(sel, 1'b0);
            exp_v = k / (settle + 1);
            if (exp_v > 3) exp_v = 3;
            if (int'(get_vec(sel)) != exp_v) trace_errs++;
            if (get_busy(sel) != (k < 4 * (settle + 1))) trace_errs++;
            if (get_done(sel)) begin
                latency = k;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if ({a2, b2, busy2, done2, pass2} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {a2, b2, busy2, done2, pass2});
        end
        checks++;
        if ({err2, ffv2, ffm2} !== 13'h0) begin
            errors++;
            $display("FAIL reset_results: got %h expected 0", {err2, ffv2, ffm2});
        end
        checks++;
        if ({done1, busy1, done15, busy15, a1, b1, a15, b15} !== 8'h0) begin
            errors++;
            $display("FAIL reset_others: got %b expected 0", {done1, busy1, done15, busy15, a1, b1, a15, b15});
        end
    endtask

    task automatic test_golden();
        int lat, terr;
        run_sweep(2, 2, -10, lat, terr);
        checks++;
        if (lat != 12) begin errors++; $display("FAIL golden_latency: got %0d expected 12", lat); end
        checks++;
        if (terr != 0) begin errors++; $display("FAIL golden_trace: got %0d expected 0", terr); end
        checks++;
        if ({pass2, err2, ffm2} !== {1'b1, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL golden_result: got pass=%b err=%0d mask=%h expected pass=1 err=0 mask=00", pass2, err2, ffm2);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done2, pass2, busy2, a2, b2} !== 5'b11011) begin
            errors++;
            $display("FAIL golden_hold: got %b expected 11011", {done2, pass2, busy2, a2, b2});
        end
    endtask

    task automatic test_xor_stuck();
        int lat, terr;
        xor_stuck0 = 1'b1;
        run_sweep(2, 2, -10, lat, terr);
        xor_stuck0 = 1'b0;
        checks++;
        if ({pass2, err2, ffv2, ffm2} !== {1'b0, 3'd2, 2'b01, 8'h08}) begin
            errors++;
            $display("FAIL xor_stuck: got pass=%b err=%0d vec=%b mask=%h expected pass=0 err=2 vec=01 mask=08",
                     pass2, err2, ffv2, ffm2);
        end
    endtask

    // Only the final vector (11) fails: PASS must still see it.
    task automatic test_and_stuck();
        int lat, terr;
        and_stuck0 = 1'b1;
        run_sweep(2, 2, -10, lat, terr);
        and_stuck0 = 1'b0;
        checks++;
        if ({done2, pass2, err2, ffv2, ffm2} !== {1'b1, 1'b0, 3'd1, 2'b11, 8'h80}) begin
            errors++;
            $display("FAIL and_stuck: got done=%b pass=%b err=%0d vec=%b mask=%h expected done=1 pass=0 err=1 vec=11 mask=80",
                     done2, pass2, err2, ffv2, ffm2);
        end
    endtask

    task automatic test_all_zero();
        int lat, terr;
        all_zero = 1'b1;
        run_sweep(2, 2, -10, lat, terr);
        checks++;
        if ({pass2, err2, ffv2, ffm2} !== {1'b0, 3'd4, 2'b00, 8'h36}) begin
            errors++;
            $display("FAIL all_zero: got pass=%b err=%0d vec=%b mask=%h expected pass=0 err=4 vec=00 mask=36",
                     pass2, err2, ffv2, ffm2);
        end
        // Restart from DONE with the fault still present: results clear, then repeat.
        run_sweep(2, 2, -10, lat, terr);
        all_zero = 1'b0;
        checks++;
        if ({snap_done, snap_pass, snap_busy, snap_err, snap_ffm} !== {1'b0, 1'b0, 1'b1, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL restart_clear: got done=%b pass=%b busy=%b err=%0d mask=%h expected done=0 pass=0 busy=1 err=0 mask=00",
                     snap_done, snap_pass, snap_busy, snap_err, snap_ffm);
        end
        checks++;
        if ({lat[7:0], err2, ffv2, ffm2} !== {8'd12, 3'd4, 2'b00, 8'h36}) begin
            errors++;
            $display("FAIL restart_repeat: got lat=%0d err=%0d vec=%b mask=%h expected lat=12 err=4 vec=00 mask=36",
                     lat, err2, ffv2, ffm2);
        end
    endtask

    task automatic test_start_ignored();
        int lat, terr;
        run_sweep(2, 2, 5, lat, terr);
        checks++;
        if (lat != 12 || terr != 0) begin
            errors++;
            $display("FAIL start_busy: got lat=%0d trace=%0d expected lat=12 trace=0", lat, terr);
        end
        checks++;
        if (pass2 !== 1'b1) begin errors++; $display("FAIL start_busy_pass: got %b expected 1", pass2); end
    endtask

    task automatic test_reset_mid();
        int lat, terr;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        // Edge 8 after START enters the CHECK cycle of vector 10.
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({a2, b2, busy2, done2} !== 4'b1010) begin
            errors++;
            $display("FAIL mid_position: got %b expected 1010", {a2, b2, busy2, done2});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a2, b2, busy2, done2, pass2, err2, ffv2, ffm2} !== 18'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0", {a2, b2, busy2, done2, pass2, err2, ffv2, ffm2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(2, 2, -10, lat, terr);
        checks++;
        if (lat != 12 || {pass2, err2} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL mid_rerun: got lat=%0d pass=%b err=%0d expected lat=12 pass=1 err=0", lat, pass2, err2);
        end
    endtask

    task automatic test_settle_1();
        int lat, terr;
        run_sweep(1, 1, -10, lat, terr);
        checks++;
        if (lat != 8 || terr != 0) begin
            errors++;
            $display("FAIL settle1: got lat=%0d trace=%0d expected lat=8 trace=0", lat, terr);
        end
        checks++;
        if ({pass1, err1, ffm1} !== {1'b1, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL settle1_result: got pass=%b err=%0d mask=%h expected pass=1 err=0 mask=00", pass1, err1, ffm1);
        end
    endtask

    task automatic test_settle_15();
        int lat, terr;
        run_sweep(15, 15, -10, lat, terr);
        checks++;
        if (lat != 64 || terr != 0) begin
            errors++;
            $display("FAIL settle15: got lat=%0d trace=%0d expected lat=64 trace=0", lat, terr);
        end
        checks++;
        if ({pass15, err15, ffv15, ffm15} !== {1'b1, 3'd0, 2'b00, 8'h00}) begin
            errors++;
            $display("FAIL settle15_result: got pass=%b err=%0d mask=%h expected pass=1 err=0 mask=00", pass15, err15, ffm15);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start2     = 1'b0;
        start1     = 1'b0;
        start15    = 1'b0;
        xor_stuck0 = 1'b0;
        and_stuck0 = 1'b0;
        all_zero   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_golden();
        test_xor_stuck();
        test_and_stuck();
        test_all_zero();
        test_start_ignored();
        test_reset_mid();
        test_settle_1();
        test_settle_15();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/basic_gates_checker.md
Name: basic_gates_checker

Overview:
- Self-checking exerciser for the two-input basic-gates block. It sits on the other side of that block's interface: it drives A/B and reads back all eight gate outputs.
- On START it sweeps the four input combinations, holding each for a programmable settle time. It compares the returned outputs against internally computed expected values.
- It reports PASS/FAIL, an error count and the first failing vector. Intended for power-on self-test and for bring-up of gate-library cells.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held on A_OUT/B_OUT before the inputs are sampled; legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  single-cycle request to run a sweep
- A_OUT  output  1  drives A of the gates block
- B_OUT  output  1  drives B of the gates block
- AB_AND, AB_OR, AB_NAND, AB_NOR, AB_XOR, AB_XNOR, A_INV, B_BUFF  input  1 each  returned gate outputs
- BUSY  output  1  sweep in progress
- DONE  output  1  sweep complete; held until the next START or reset
- PASS  output  1  valid while DONE; 1 = zero mismatches
- ERR_COUNT  output  3  number of failing vectors, 0..4
- FIRST_FAIL_VEC  output  2  {A,B} of the first failing vector
- FIRST_FAIL_MASK  output  8  expected XOR actual for the first failing vector; 0 if none

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0.
- Observed vector, MSB..LSB: {AB_AND, AB_OR, AB_NAND, AB_NOR, AB_XOR, AB_XNOR, A_INV, B_BUFF}.
- Vector index v = {A_OUT, B_OUT}, swept in order 00, 01, 10, 11.
- Expected values: v=00 -> 8'h36; v=01 -> 8'h6B; v=10 -> 8'h68; v=11 -> 8'hC5.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - START=1 -> SETTLE.
  - At the same edge: v=00; settle counter = SETTLE_CYCLES-1; BUSY=1.
  - Also at that edge: DONE, PASS, ERR_COUNT and FIRST_FAIL_* are cleared.
- SETTLE: counter decrements each cycle; at 0 -> CHECK.
  - A vector is therefore held for SETTLE_CYCLES cycles, followed by one CHECK cycle.
- CHECK (one cycle): the eight inputs are sampled and compared at the edge ending the cycle.
  - On mismatch: ERR_COUNT increments.
  - On the first mismatch of the sweep only: FIRST_FAIL_VEC=v and FIRST_FAIL_MASK=expected^actual.
  - If v<3: v increments, counter reloads, state -> SETTLE.
  - If v=3: state -> DONE; at that edge BUSY=0, DONE=1, PASS=(final ERR_COUNT==0).
  - PASS must include the last vector's result; it uses the combinational next count.
- Sweep latency: DONE rises 4*(SETTLE_CYCLES+1) edges after the edge that samples START.
- DONE state:
  - Outputs hold. A_OUT/B_OUT stay at 11.
  - START=1 -> restarts exactly as from IDLE.
- START while BUSY is ignored and does not restart or extend the sweep.
- ERR_COUNT is 3 bits, max 4, so no saturation is needed.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. No partial result is retained.
- Inputs are assumed synchronous to CLK, since the gates block is combinational from A_OUT/B_OUT. No synchronisers are used.

Decomposition:
- Shared package basic_gates_pkg holds:
  - state enum for IDLE/SETTLE/CHECK/DONE;
  - localparams EXP_00=8'h36, EXP_01=8'h6B, EXP_10=8'h68, EXP_11=8'hC5;
  - bit-position constants for the observed vector ordering.
- One natural sub-module: basic_gates_expect, a pure combinational v -> expected-vector lookup, reusable by the testbench scoreboard.
- FSM, counters and result registers stay in the top module.

Test Plan:
- Golden DUT (real gates block connected), SETTLE_CYCLES=2, START pulse -> DONE after 12 cycles, PASS=1, ERR_COUNT=0, FIRST_FAIL_MASK=8'h00.
- AB_XOR stuck-at-0 -> ERR_COUNT=2, PASS=0, FIRST_FAIL_VEC=2'b01, FIRST_FAIL_MASK=8'h08.
- All eight inputs tied 0 -> ERR_COUNT=4, FIRST_FAIL_VEC=2'b00, FIRST_FAIL_MASK=8'h36.
- START re-pulsed on cycle 5 of a sweep -> ignored; DONE still at cycle 12. A START while in DONE clears results and reruns, giving an identical outcome.
- RST_N asserted during the CHECK of v=10 -> all outputs 0 immediately. A subsequent START completes a clean sweep with PASS=1.
- SETTLE_CYCLES=1 and =15 -> A_OUT/B_OUT each held exactly 1 or 15 cycles before sampling. DONE at cycle 8 and cycle 64 respectively.
